vram_write_queue: RTL and testbench
===================================

// Module: vram_write_queue
// PURPOSE
//  Receiving end of the CPU-snoop -> VRAM write path. Accepts byte write requests from the
//  snoop logic, buffers them in a small FIFO, and drains them into VRAM only in the write
//  slot of the 8-pixel fetch sequence, never while the video fetch owns the VRAM bus.
//  Sits between the snoop logic and the top-level VRAM address/data/strobe muxing.
// PARAMETERS
//  ADDR_W      15    VRAM address width
//  DATA_W      8     VRAM data width
//  DEPTH       4     FIFO entries; power of two, 2..16
//  WRITE_SLOT  3'd4  seq value on which a drain may start
//  COALESCE    1     1 = a push to the same address as the newest undrained entry overwrites it
// PORTS
//  pixClk       in   1       25.175MHz pixel clock; all state on rising edge
//  nReset       in   1       asynchronous, active-low reset
//  seq          in   3       hCount[2:0] from timing generator
//  vidBusy      in   1       1 = video fetch owns VRAM this cycle (nvramOE low)
//  wrReq        in   1       one-cycle push strobe from snoop logic
//  wrAddr       in   ADDR_W  VRAM address of push
//  wrData       in   DATA_W  byte to write
//  vramAddr     out  ADDR_W  address of write in progress
//  vramDataOut  out  DATA_W  data of write in progress
//  vramDrive    out  1       1 = this block owns VRAM addr/data bus (top-level mux select)
//  nvramWEpre   out  1       active-low write strobe, ORed with pixClk at top level
//  level        out  $clog2(DEPTH)+1  current FIFO occupancy
//  overflow     out  1       sticky: a push was dropped
//  clrOverflow  in   1       synchronous clear of overflow
// BEHAVIOUR
//  Reset: FIFO empty, level=0, state IDLE, vramAddr=0, vramDataOut=0, vramDrive=0,
//   nvramWEpre=1, overflow=0. Reset mid-write abandons the write; strobe returns high at once.
//  Push: on edge with wrReq=1. Coalesce (COALESCE=1, level>0, wrAddr equals newest entry's
//   address, newest entry not being popped this cycle) -> overwrite its data, level unchanged.
//   Else if level<DEPTH, or a pop occurs on the same edge -> append. Else drop, overflow<=1.
//  Overflow: set wins over clrOverflow on the same edge.
//  FSM, all outputs registered:
//   IDLE   -> STROBE when seq==WRITE_SLOT && !vidBusy && level>0: load head into
//             vramAddr/vramDataOut, pop head, vramDrive<=1, nvramWEpre<=0.
//   STROBE -> HOLD unconditionally: nvramWEpre<=1, vramDrive stays 1 (data hold cycle).
//   HOLD   -> IDLE unconditionally: vramDrive<=0; vramAddr/vramDataOut keep last values.
//  Strobe low exactly 1 pixClk cycle; at most one drain per 8-cycle sequence; latency from
//   push to strobe 1..8 cycles when queue empty and slot free.
//  vidBusy sampled only at WRITE_SLOT; if busy, drain waits for the next sequence.
//  Simultaneous push+pop at level==DEPTH: accepted, level stays DEPTH. Push+pop at level==1
//   with coalesce match on the popped entry: no coalesce, append instead.
//  Pointers wrap modulo DEPTH; level arithmetic unsigned, never under/overflows.
//  FIFO order preserved; entries never reordered.
// STRUCTURE
//  Shared package sevga_pkg: ADDR_W/DATA_W constants, typedef struct {addr,data} vram_wr_t,
//   typedef enum logic [1:0] {WQ_IDLE, WQ_STROBE, WQ_HOLD} wq_state_t.
//  One sub-module: vram_wq_fifo (DEPTH x vram_wr_t, push/pop/overwrite-newest, level, full).
//  FSM, coalesce compare, and overflow flag live in the top of this block.
// TESTING
//  1 Reset asserted mid-STROBE -> nvramWEpre=1, vramDrive=0, level=0 immediately, async.
//  2 Push 0x1234/0xA5 at seq=1, vidBusy=0 -> STROBE at seq=4 edge, vramAddr=0x1234,
//    vramDataOut=0xA5, nvramWEpre low 1 cycle, vramDrive high 2 cycles, level 1->0.
//  3 Push 5 distinct addresses back-to-back, DEPTH=4, no drain slot -> level=4, overflow=1,
//    5th dropped; clrOverflow -> 0; four drains in 4 consecutive sequences, in push order.
//  4 Push 0x0100/0x11 then 0x0100/0x22 -> level=1, single write of 0x22; with COALESCE=0
//    -> level=2, writes 0x11 then 0x22.
//  5 vidBusy=1 at WRITE_SLOT with level=2 -> no strobe that sequence; drains resume next.
//  6 level=4, push on the same edge as a drain pop -> accepted, level=4, overflow stays 0.

Source files
------------

// File: rtl/sevga_pkg.sv
// Shared types for the sevga VRAM path.
//   ADDR_W / DATA_W : VRAM address and data widths
//   vram_wr_t       : one buffered byte write (address + data)
//   wq_state_t      : write-queue drain sequencer states
package sevga_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } vram_wr_t;

  typedef enum logic [1:0] {
    WQ_IDLE   = 2'd0,
    WQ_STROBE = 2'd1,
    WQ_HOLD   = 2'd2
  } wq_state_t;

endpackage

// File: rtl/vram_wq_fifo.sv
// Small circular FIFO of pending VRAM writes.
//   pixClk, nReset : clock, asynchronous active-low reset
//   push           : append wrEntry at the tail (caller guarantees room or a same-edge pop)
//   pop            : drop the head entry (caller guarantees level > 0)
//   overwrite      : replace the newest entry with wrEntry (ignored when push is set)
//   headEntry      : oldest entry, valid when level > 0
//   newestAddr     : address of the newest entry, valid when level > 0
//   level, full    : occupancy, and level == DEPTH
module vram_wq_fifo
  import sevga_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              pixClk,
  input  logic              nReset,
  input  logic              push,
  input  logic              pop,
  input  logic              overwrite,
  input  vram_wr_t          wrEntry,
  output vram_wr_t          headEntry,
  output logic [ADDR_W-1:0] newestAddr,
  output logic [LVL_W-1:0]  level,
  output logic              full
);

  vram_wr_t           mem [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   newestPtr;

  // DEPTH is a power of two, so pointer arithmetic wraps modulo DEPTH on its own.
  assign newestPtr  = wrPtr - PTR_W'(1);
  assign headEntry  = mem[rdPtr];
  assign newestAddr = mem[newestPtr].addr;
  assign full       = (level == LVL_W'(DEPTH));

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      level <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage has no reset; contents are only read behind a nonzero level.
  always_ff @(posedge pixClk) begin
    if (push)           mem[wrPtr]     <= wrEntry;
    else if (overwrite) mem[newestPtr] <= wrEntry;
  end

endmodule

// File: rtl/vram_write_queue.sv
// Receiving end of the CPU-snoop -> VRAM write path. Buffers byte writes and
// drains one per 8-pixel fetch sequence in the write slot, when video is idle.
//   pixClk, nReset        : pixel clock, asynchronous active-low reset
//   seq, vidBusy          : fetch sequence position and video bus ownership
//   wrReq, wrAddr, wrData : one-cycle push from the snoop logic
//   vramAddr, vramDataOut : address/data of the write in progress
//   vramDrive             : this block owns the VRAM addr/data bus
//   nvramWEpre            : active-low write strobe (ORed with pixClk at top level)
//   level                 : FIFO occupancy
//   overflow, clrOverflow : sticky dropped-push flag and its synchronous clear
// ADDR_W and DATA_W come from sevga_pkg.
module vram_write_queue
  import sevga_pkg::*;
#(
  parameter  int         DEPTH      = 4,
  parameter  logic [2:0] WRITE_SLOT = 3'd4,
  parameter  bit         COALESCE   = 1'b1,
  localparam int         LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic              pixClk,
  input  logic              nReset,
  input  logic [2:0]        seq,
  input  logic              vidBusy,
  input  logic              wrReq,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic [ADDR_W-1:0] vramAddr,
  output logic [DATA_W-1:0] vramDataOut,
  output logic              vramDrive,
  output logic              nvramWEpre,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  input  logic              clrOverflow
);

  wq_state_t         state;
  vram_wr_t          wrEntry;
  vram_wr_t          headEntry;
  logic [ADDR_W-1:0] newestAddr;
  logic              full;
  logic              popNow;
  logic              newestPopped;
  logic              coalesceHit;
  logic              pushNow;
  logic              dropNow;

  assign wrEntry = '{addr: wrAddr, data: wrData};

  // A drain starts only from IDLE, so at most one strobe fits in each sequence.
  assign popNow = (state == WQ_IDLE) && (seq == WRITE_SLOT) && !vidBusy && (level != '0);

  // When the only entry leaves on this edge it is already committed to VRAM;
  // a matching push must become a new entry rather than vanish with it.
  assign newestPopped = popNow && (level == LVL_W'(1));
  assign coalesceHit  = COALESCE && wrReq && (level != '0) &&
                        (wrAddr == newestAddr) && !newestPopped;

  assign pushNow = wrReq && !coalesceHit && (!full || popNow);
  assign dropNow = wrReq && !coalesceHit && full && !popNow;

  vram_wq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .pixClk     (pixClk),
    .nReset     (nReset),
    .push       (pushNow),
    .pop        (popNow),
    .overwrite  (coalesceHit),
    .wrEntry    (wrEntry),
    .headEntry  (headEntry),
    .newestAddr (newestAddr),
    .level      (level),
    .full       (full)
  );

  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      state       <= WQ_IDLE;
      vramAddr    <= '0;
      vramDataOut <= '0;
      vramDrive   <= 1'b0;
      nvramWEpre  <= 1'b1;
    end else begin
      case (state)
        WQ_IDLE: begin
          if (popNow) begin
            vramAddr    <= headEntry.addr;
            vramDataOut <= headEntry.data;
            vramDrive   <= 1'b1;
            nvramWEpre  <= 1'b0;
            state       <= WQ_STROBE;
          end
        end
        // Strobe rises here while address/data stay driven for one hold cycle.
        WQ_STROBE: begin
          nvramWEpre <= 1'b1;
          state      <= WQ_HOLD;
        end
        WQ_HOLD: begin
          vramDrive <= 1'b0;
          state     <= WQ_IDLE;
        end
        default: begin
          vramDrive  <= 1'b0;
          nvramWEpre <= 1'b1;
          state      <= WQ_IDLE;
        end
      endcase
    end
  end

  // A dropped push on the same edge as a clear leaves the flag set.
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset)          overflow <= 1'b0;
    else if (dropNow)     overflow <= 1'b1;
    else if (clrOverflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_vram_write_queue.sv
// Self-checking bench for vram_write_queue. Two instances share all stimulus:
// dut (COALESCE=1) and dutNc (COALESCE=0). Expected VRAM writes are queued as
// stimulus is issued; monitors pop and compare on every observed strobe.
module tb_vram_write_queue;
  import sevga_pkg::*;

  logic              pixClk = 1'b0;
  logic              nReset;
  logic [2:0]        seq;
  logic              vidBusy;
  logic              wrReq;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              clrOverflow;

  logic [ADDR_W-1:0] vramAddr,    vramAddrNc;
  logic [DATA_W-1:0] vramDataOut, vramDataOutNc;
  logic              vramDrive,   vramDriveNc;
  logic              nvramWEpre,  nvramWEpreNc;
  logic [2:0]        level,       levelNc;
  logic              overflow,    overflowNc;

  int checks = 0;
  int errors = 0;
  vram_wr_t expQ[$];
  vram_wr_t expQNc[$];

  always #5 pixClk = ~pixClk;

  vram_write_queue #(.DEPTH(4), .WRITE_SLOT(3'd4), .COALESCE(1'b1)) dut (
    .pixClk(pixClk), .nReset(nReset), .seq(seq), .vidBusy(vidBusy),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData),
    .vramAddr(vramAddr), .vramDataOut(vramDataOut), .vramDrive(vramDrive),
    .nvramWEpre(nvramWEpre), .level(level), .overflow(overflow),
    .clrOverflow(clrOverflow)
  );

  vram_write_queue #(.DEPTH(4), .WRITE_SLOT(3'd4), .COALESCE(1'b0)) dutNc (
    .pixClk(pixClk), .nReset(nReset), .seq(seq), .vidBusy(vidBusy),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData),
    .vramAddr(vramAddrNc), .vramDataOut(vramDataOutNc), .vramDrive(vramDriveNc),
    .nvramWEpre(nvramWEpreNc), .level(levelNc), .overflow(overflowNc),
    .clrOverflow(clrOverflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One pixel clock: inputs change 1ns after the edge, seq advances like hCount[2:0].
  task automatic tick();
    @(posedge pixClk);
    #1;
    seq = seq + 3'd1;
  endtask

  task automatic waitSeq(input logic [2:0] v);
    for (int i = 0; i < 8 && seq != v; i++) tick();
  endtask

  task automatic expectBoth(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    expQ.push_back('{addr: a, data: d});
    expQNc.push_back('{addr: a, data: d});
  endtask

  task automatic pushOne(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wrReq  = 1'b1;
    wrAddr = a;
    wrData = d;
    tick();
    wrReq  = 1'b0;
  endtask

  // Write scoreboards, sampled on the falling edge.
  always @(negedge pixClk) begin
    if (nReset && !nvramWEpre) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut unexpected write: addr 0x%0h data 0x%0h, expected none", vramAddr, vramDataOut);
      end else begin
        vram_wr_t e;
        e = expQ.pop_front();
        check("dut write addr", 32'(vramAddr), 32'(e.addr));
        check("dut write data", 32'(vramDataOut), 32'(e.data));
        check("dut drive during strobe", 32'(vramDrive), 32'd1);
      end
    end
  end

  always @(negedge pixClk) begin
    if (nReset && !nvramWEpreNc) begin
      if (expQNc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dutNc unexpected write: addr 0x%0h data 0x%0h, expected none", vramAddrNc, vramDataOutNc);
      end else begin
        vram_wr_t e;
        e = expQNc.pop_front();
        check("dutNc write addr", 32'(vramAddrNc), 32'(e.addr));
        check("dutNc write data", 32'(vramDataOutNc), 32'(e.data));
      end
    end
  end

  // Strobe must be low for a single cycle; drive must span exactly two cycles.
  logic prevLow = 1'b0;
  int   driveRun = 0;
  always @(negedge pixClk) begin
    if (!nReset) begin
      prevLow  = 1'b0;
      driveRun = 0;
    end else begin
      if (!nvramWEpre) check("strobe single cycle", 32'(prevLow), 32'd0);
      prevLow = !nvramWEpre;
      if (vramDrive) driveRun++;
      else if (driveRun != 0) begin
        check("drive width", 32'(driveRun), 32'd2);
        driveRun = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset      = 1'b0;
    seq         = 3'd0;
    vidBusy     = 1'b0;
    wrReq       = 1'b0;
    wrAddr      = '0;
    wrData      = '0;
    clrOverflow = 1'b0;
    tick();
    tick();
    nReset = 1'b1;

    // Reset state
    check("reset level",      32'(level),       32'd0);
    check("reset overflow",   32'(overflow),    32'd0);
    check("reset nvramWEpre", 32'(nvramWEpre),  32'd1);
    check("reset vramDrive",  32'(vramDrive),   32'd0);
    check("reset vramAddr",   32'(vramAddr),    32'd0);
    check("reset vramData",   32'(vramDataOut), 32'd0);

    // Reset asserted mid-strobe abandons the write at once
    waitSeq(3'd1);
    pushOne(15'h0777, 8'h5A);
    waitSeq(3'd4);
    tick();
    check("pre-reset strobe low", 32'(nvramWEpre), 32'd0);
    nReset = 1'b0;
    #1;
    check("async reset nvramWEpre", 32'(nvramWEpre), 32'd1);
    check("async reset vramDrive",  32'(vramDrive),  32'd0);
    check("async reset level",      32'(level),      32'd0);
    tick();
    nReset = 1'b1;

    // Single push: strobe on the seq=4 edge
    waitSeq(3'd1);
    expectBoth(15'h1234, 8'hA5);
    pushOne(15'h1234, 8'hA5);
    check("single level after push", 32'(level), 32'd1);
    waitSeq(3'd4);
    tick();
    check("single strobe low",   32'(nvramWEpre), 32'd0);
    check("single drive high",   32'(vramDrive),  32'd1);
    check("single level popped", 32'(level),      32'd0);
    tick();
    check("hold strobe high", 32'(nvramWEpre), 32'd1);
    check("hold drive high",  32'(vramDrive),  32'd1);
    tick();
    check("idle drive low",  32'(vramDrive),   32'd0);
    check("idle addr kept",  32'(vramAddr),    32'h1234);
    check("idle data kept",  32'(vramDataOut), 32'hA5);

    // Overfill: 5th push dropped, set beats clear on the same edge
    vidBusy = 1'b1;
    waitSeq(3'd5);
    for (int i = 0; i < 5; i++) begin
      clrOverflow = (i == 4);
      if (i < 4) expectBoth(15'h0400 + 15'(i), 8'h80 + 8'(i));
      pushOne(15'h0400 + 15'(i), 8'h80 + 8'(i));
    end
    clrOverflow = 1'b0;
    check("full level",          32'(level),      32'd4);
    check("overflow set",        32'(overflow),   32'd1);
    check("overflow set (NC)",   32'(overflowNc), 32'd1);
    clrOverflow = 1'b1;
    tick();
    clrOverflow = 1'b0;
    check("overflow cleared", 32'(overflow), 32'd0);
    vidBusy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      waitSeq(3'd4);
      tick();
      check("drain each sequence", 32'(nvramWEpre), 32'd0);
    end
    check("drained level", 32'(level), 32'd0);

    // Coalescing on the newest entry
    waitSeq(3'd5);
    expQ.push_back('{addr: 15'h0100, data: 8'h22});
    expQNc.push_back('{addr: 15'h0100, data: 8'h11});
    expQNc.push_back('{addr: 15'h0100, data: 8'h22});
    pushOne(15'h0100, 8'h11);
    pushOne(15'h0100, 8'h22);
    check("coalesce level",    32'(level),   32'd1);
    check("no-coalesce level", 32'(levelNc), 32'd2);
    waitSeq(3'd4);
    tick();
    waitSeq(3'd4);
    tick();
    check("coalesce drained",    32'(level),   32'd0);
    check("no-coalesce drained", 32'(levelNc), 32'd0);

    // Video busy at the write slot defers the drain by one sequence
    waitSeq(3'd5);
    expectBoth(15'h0200, 8'h33);
    expectBoth(15'h0201, 8'h44);
    pushOne(15'h0200, 8'h33);
    pushOne(15'h0201, 8'h44);
    waitSeq(3'd4);
    vidBusy = 1'b1;
    tick();
    vidBusy = 1'b0;
    check("busy no strobe", 32'(nvramWEpre), 32'd1);
    check("busy level",     32'(level),      32'd2);
    waitSeq(3'd4);
    tick();
    check("resume strobe", 32'(nvramWEpre), 32'd0);
    check("resume level",  32'(level),      32'd1);
    waitSeq(3'd4);
    tick();
    check("busy drained", 32'(level), 32'd0);

    // Push on the same edge as a pop while full
    waitSeq(3'd5);
    for (int i = 0; i < 4; i++) begin
      expectBoth(15'h0500 + 15'(i), 8'h90 + 8'(i));
      pushOne(15'h0500 + 15'(i), 8'h90 + 8'(i));
    end
    check("prefill level", 32'(level), 32'd4);
    waitSeq(3'd4);
    expectBoth(15'h0504, 8'h94);
    pushOne(15'h0504, 8'h94);
    check("push+pop full level",    32'(level),      32'd4);
    check("push+pop full overflow", 32'(overflow),   32'd0);
    check("push+pop full strobe",   32'(nvramWEpre), 32'd0);
    for (int i = 0; i < 4; i++) begin
      waitSeq(3'd4);
      tick();
    end
    check("push+pop drained", 32'(level), 32'd0);

    // Matching push while the only entry is popped appends instead of coalescing
    waitSeq(3'd3);
    expectBoth(15'h0300, 8'h55);
    expectBoth(15'h0300, 8'h66);
    pushOne(15'h0300, 8'h55);
    pushOne(15'h0300, 8'h66);
    check("popped-entry append level", 32'(level), 32'd1);
    waitSeq(3'd4);
    tick();
    tick();
    tick();
    check("final level",        32'(level),          32'd0);
    check("dut writes pending",   32'(expQ.size()),   32'd0);
    check("dutNc writes pending", 32'(expQNc.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
